// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared size codes and FSM state type for the data-memory stage
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_lane_ctrl.sv
// rtl/dm_lane_ctrl.sv - byte-lane decode: enables, fault, load alignment and store replication
module dm_lane_ctrl
  import dm_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_sign_ext,
  input  logic [31:0] i_raw_word,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic        o_fault,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wdata_rep
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_raw_word >> {i_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_lane[1] ? i_raw_word[31:16] : i_raw_word[15:0];

  // A faulting access yields no enables and zero load data so the top need not re-gate.
  always_comb begin
    o_be        = 4'b0000;
    o_fault     = 1'b0;
    o_rdata     = 32'h0;
    o_wdata_rep = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_be        = 4'b0001 << i_lane;
        o_rdata     = {{24{i_sign_ext & w_byte[7]}}, w_byte};
        o_wdata_rep = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_wdata_rep = {2{i_wdata[15:0]}};
        if (i_lane[0]) begin
          o_fault = 1'b1;
        end else begin
          o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
          o_rdata = {{16{i_sign_ext & w_half[15]}}, w_half};
        end
      end
      SZ_WORD: begin
        if (i_lane != 2'b00) begin
          o_fault = 1'b1;
        end else begin
          o_be    = 4'b1111;
          o_rdata = i_raw_word;
        end
      end
      default: o_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_unit.sv
// rtl/dm_unit.sv - data memory with combinational loads, clocked stores, clear-on-reset FSM and sticky fault capture
module dm_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DEPTH_WORDS    = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       wdata,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic              err_clr,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              misalign,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  logic [31:0]       r_mem [DEPTH_WORDS];
  dm_state_e         r_state;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic              r_misalign;
  logic [ADDR_W-1:0] r_err_addr;

  logic [IDX_W-1:0]  w_word_idx;
  logic [1:0]        w_lane;
  logic [31:0]       w_raw_word;
  logic [3:0]        w_be;
  logic              w_fault;
  logic [31:0]       w_lane_rdata;
  logic [31:0]       w_wdata_rep;
  logic              w_ready;
  logic              w_fault_access;
  logic              w_wr_en;

  assign w_word_idx = dm_addr[ADDR_W-1:2];
  assign w_lane     = dm_addr[1:0];
  assign w_raw_word = r_mem[w_word_idx];
  assign w_ready    = (r_state == ST_READY);

  dm_lane_ctrl u_lane_ctrl (
    .i_size      (size),
    .i_lane      (w_lane),
    .i_sign_ext  (sign_ext),
    .i_raw_word  (w_raw_word),
    .i_wdata     (wdata),
    .o_be        (w_be),
    .o_fault     (w_fault),
    .o_rdata     (w_lane_rdata),
    .o_wdata_rep (w_wdata_rep)
  );

  assign w_fault_access = w_ready & w_fault & (mem_we | mem_re);
  assign w_wr_en        = w_ready & mem_we & ~w_fault;

  assign rdata    = (w_ready & mem_re) ? w_lane_rdata : 32'h0;
  assign busy     = ~w_ready;
  assign misalign = r_misalign;
  assign err_addr = r_err_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == LAST_IDX) begin
        r_state <= ST_READY;
      end
    end
  end

  // A new fault overrides a coincident err_clr; otherwise the first fault's address is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
      r_err_addr <= '0;
    end else if (w_fault_access) begin
      r_misalign <= 1'b1;
      if (!r_misalign || err_clr) begin
        r_err_addr <= dm_addr;
      end
    end else if (err_clr) begin
      r_misalign <= 1'b0;
      r_err_addr <= '0;
    end
  end

  // The array has no reset; the clear FSM owns the write port until READY.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= 32'h0;
    end else if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_word_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_unit.sv
// tb/tb_dm_unit.sv - directed self-checking bench for dm_unit
module tb_dm_unit;

  logic        clk;
  logic        rst_n;
  logic [9:0]  dm_addr;
  logic [31:0] wdata;
  logic        mem_we;
  logic        mem_re;
  logic [1:0]  size;
  logic        sign_ext;
  logic        err_clr;
  logic [31:0] rdata;
  logic        busy;
  logic        misalign;
  logic [9:0]  err_addr;

  int checks;
  int failures;

  dm_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dm_addr  (dm_addr),
    .wdata    (wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .size     (size),
    .sign_ext (sign_ext),
    .err_clr  (err_clr),
    .rdata    (rdata),
    .busy     (busy),
    .misalign (misalign),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    err_clr  = 1'b0;
    size     = 2'b10;
    sign_ext = 1'b0;
    dm_addr  = '0;
    wdata    = '0;
  endtask

  task automatic store(input logic [9:0] a, input logic [31:0] d, input logic [1:0] sz);
    dm_addr = a;
    wdata   = d;
    size    = sz;
    mem_we  = 1'b1;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load(input logic [9:0] a, input logic [1:0] sz, input logic sx);
    dm_addr  = a;
    size     = sz;
    sign_ext = sx;
    mem_re   = 1'b1;
    #2;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    checks++;
    if (err_addr !== 10'h0) begin failures++; $display("FAIL reset_err_addr got=%h exp=000", err_addr); end
    rst_n = 1'b1;
    wait_clear(n);
    checks++;
    if (n != 256) begin failures++; $display("FAIL clear_cycles got=%0d exp=256", n); end
    load(10'h000, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL cleared_w0 got=%h exp=00000000", rdata); end
    load(10'h3FC, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL cleared_w255 got=%h exp=00000000", rdata); end
    load(10'h200, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL cleared_w128 got=%h exp=00000000", rdata); end
    idle();
  endtask

  task automatic test_sign_ext();
    store(10'h010, 32'h8000_00FF, 2'b10);
    load(10'h010, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h8000_00FF) begin failures++; $display("FAIL lw_010 got=%h exp=800000ff", rdata); end
    load(10'h010, 2'b00, 1'b1);
    checks++;
    if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL lb_010 got=%h exp=ffffffff", rdata); end
    load(10'h010, 2'b00, 1'b0);
    checks++;
    if (rdata !== 32'h0000_00FF) begin failures++; $display("FAIL lbu_010 got=%h exp=000000ff", rdata); end
    load(10'h012, 2'b01, 1'b1);
    checks++;
    if (rdata !== 32'hFFFF_8000) begin failures++; $display("FAIL lh_012 got=%h exp=ffff8000", rdata); end
    load(10'h012, 2'b01, 1'b0);
    checks++;
    if (rdata !== 32'h0000_8000) begin failures++; $display("FAIL lhu_012 got=%h exp=00008000", rdata); end
    load(10'h013, 2'b00, 1'b1);
    checks++;
    if (rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_013 got=%h exp=ffffff80", rdata); end
    dm_addr = 10'h010;
    mem_re  = 1'b0;
    #2;
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL re_low got=%h exp=00000000", rdata); end
    idle();
  endtask

  task automatic test_sub_store();
    store(10'h014, 32'h1122_3344, 2'b10);
    store(10'h015, 32'hFFFF_FFAB, 2'b00);
    load(10'h014, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h1122_AB44) begin failures++; $display("FAIL sb_015 got=%h exp=1122ab44", rdata); end
    store(10'h016, 32'h1234_BEEF, 2'b01);
    load(10'h014, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'hBEEF_AB44) begin failures++; $display("FAIL sh_016 got=%h exp=beefab44", rdata); end
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL legal_no_fault got=%b exp=0", misalign); end
    idle();
  endtask

  task automatic test_misalign();
    store(10'h006, 32'hDEAD_BEEF, 2'b10);
    checks++;
    if (misalign !== 1'b1) begin failures++; $display("FAIL sw006_misalign got=%b exp=1", misalign); end
    checks++;
    if (err_addr !== 10'h006) begin failures++; $display("FAIL sw006_err_addr got=%h exp=006", err_addr); end
    load(10'h004, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL sw006_suppressed got=%h exp=00000000", rdata); end
    load(10'h001, 2'b01, 1'b0);
    @(posedge clk);
    #1;
    idle();
    checks++;
    if (err_addr !== 10'h006) begin failures++; $display("FAIL first_fault_wins got=%h exp=006", err_addr); end
    store(10'h014, 32'h0, 2'b11);
    load(10'h014, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'hBEEF_AB44) begin failures++; $display("FAIL size11_suppressed got=%h exp=beefab44", rdata); end
    load(10'h016, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL faulty_load_zero got=%h exp=00000000", rdata); end
    idle();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    idle();
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL err_clr_misalign got=%b exp=0", misalign); end
    checks++;
    if (err_addr !== 10'h0) begin failures++; $display("FAIL err_clr_addr got=%h exp=000", err_addr); end
  endtask

  task automatic test_clr_collision();
    store(10'h006, 32'h0, 2'b10);
    err_clr = 1'b1;
    store(10'h003, 32'h0000_5555, 2'b01);
    checks++;
    if (misalign !== 1'b1) begin failures++; $display("FAIL collide_misalign got=%b exp=1", misalign); end
    checks++;
    if (err_addr !== 10'h003) begin failures++; $display("FAIL collide_err_addr got=%h exp=003", err_addr); end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_top_and_rbw();
    store(10'h3FF, 32'h0000_005A, 2'b00);
    load(10'h3FC, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h5A00_0000) begin failures++; $display("FAIL top_lw got=%h exp=5a000000", rdata); end
    load(10'h3FF, 2'b00, 1'b0);
    checks++;
    if (rdata !== 32'h0000_005A) begin failures++; $display("FAIL top_lbu got=%h exp=0000005a", rdata); end
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL top_no_fault got=%b exp=0", misalign); end
    idle();
    store(10'h030, 32'h0102_0304, 2'b10);
    dm_addr = 10'h030;
    wdata   = 32'hAABB_CCDD;
    size    = 2'b10;
    mem_we  = 1'b1;
    mem_re  = 1'b1;
    #2;
    checks++;
    if (rdata !== 32'h0102_0304) begin failures++; $display("FAIL rbw_old got=%h exp=01020304", rdata); end
    @(posedge clk);
    #1;
    idle();
    load(10'h030, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'hAABB_CCDD) begin failures++; $display("FAIL rbw_new got=%h exp=aabbccdd", rdata); end
    idle();
  endtask

  task automatic test_midclear_reset();
    int n;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midclear_busy got=%b exp=1", busy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    store(10'h040, 32'h1234_5678, 2'b10);
    load(10'h040, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL busy_rdata got=%h exp=00000000", rdata); end
    idle();
    wait_clear(n);
    checks++;
    if (n != 255) begin failures++; $display("FAIL midclear_cycles got=%0d exp=255", n); end
    load(10'h040, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL busy_store_dropped got=%h exp=00000000", rdata); end
    load(10'h030, 2'b10, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL reclear_030 got=%h exp=00000000", rdata); end
    idle();
  endtask

  // The mid-clear test consumes one clear cycle with the dropped store, so 255 edges remain.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    test_reset();
    test_sign_ext();
    test_sub_store();
    test_misalign();
    test_clr_collision();
    test_top_and_rbw();
    test_midclear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
